// File: rtl/module_display_scan_8dig.sv
// rtl/module_display_scan_8dig.sv - 8-digit multiplexed 7-segment scanner with double-buffered data
module module_display_scan_8dig #(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   data,
    input  logic [N_DIGITS-1:0]     dp_n,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic                    load,
    output logic [N_DIGITS-1:0]     enable,
    output logic [7:0]              segments,
    output logic                    slot_done
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);

    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] BLANK_END  = PRE_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

    logic [PRE_W-1:0]        prescaler;
    logic [IDX_W-1:0]        index;

    logic [4*N_DIGITS-1:0]   pend_data;
    logic [N_DIGITS-1:0]     pend_dp_n;
    logic [N_DIGITS-1:0]     pend_en;
    logic [4*N_DIGITS-1:0]   act_data;
    logic [N_DIGITS-1:0]     act_dp_n;
    logic [N_DIGITS-1:0]     act_en;

    logic                    slot_wrap;
    logic                    frame_wrap;
    logic [3:0]              nibble;
    logic                    lit;
    logic [N_DIGITS-1:0]     enable_next;
    logic [7:0]              segments_next;

    // Active-low g..a pattern for one hex digit
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0:    hex_to_seg = 7'b1000000;
            4'h1:    hex_to_seg = 7'b1111001;
            4'h2:    hex_to_seg = 7'b0100100;
            4'h3:    hex_to_seg = 7'b0110000;
            4'h4:    hex_to_seg = 7'b0011001;
            4'h5:    hex_to_seg = 7'b0010010;
            4'h6:    hex_to_seg = 7'b0000010;
            4'h7:    hex_to_seg = 7'b1111000;
            4'h8:    hex_to_seg = 7'b0000000;
            4'h9:    hex_to_seg = 7'b0010000;
            4'hA:    hex_to_seg = 7'b0001000;
            4'hB:    hex_to_seg = 7'b0000011;
            4'hC:    hex_to_seg = 7'b1000110;
            4'hD:    hex_to_seg = 7'b0100001;
            4'hE:    hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    assign slot_wrap  = (prescaler == PRE_LAST);
    assign frame_wrap = slot_wrap && (index == IDX_LAST);
    assign slot_done  = slot_wrap;

    // Slot timer and digit pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            index     <= '0;
        end else if (slot_wrap) begin
            prescaler <= '0;
            index     <= frame_wrap ? '0 : index + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Pending/active buffers; active only changes at the frame boundary so a frame never tears
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_data <= '0;
            pend_dp_n <= '0;
            pend_en   <= '0;
            act_data  <= '0;
            act_dp_n  <= '0;
            act_en    <= '0;
        end else begin
            if (load) begin
                pend_data <= data;
                pend_dp_n <= dp_n;
                pend_en   <= digit_en;
            end
            if (frame_wrap) begin
                act_data <= load ? data     : pend_data;
                act_dp_n <= load ? dp_n     : pend_dp_n;
                act_en   <= load ? digit_en : pend_en;
            end
        end
    end

    // Pin values for the current digit, blanked at slot start to suppress ghosting
    always_comb begin
        nibble        = act_data[{index, 2'b00} +: 4];
        lit           = (prescaler >= BLANK_END) && act_en[index];
        enable_next   = '1;
        segments_next = 8'hFF;
        if (lit) begin
            enable_next[index] = 1'b0;
            segments_next      = {act_dp_n[index], hex_to_seg(nibble)};
        end
    end

    // Registered pin drive, one cycle behind the scan state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable   <= '1;
            segments <= 8'hFF;
        end else begin
            enable   <= enable_next;
            segments <= segments_next;
        end
    end

endmodule

// File: tb/tb_module_display_scan_8dig.sv
// tb/tb_module_display_scan_8dig.sv - scoreboard bench for the 8-digit display scanner
module tb_module_display_scan_8dig;

    logic        clk;
    logic        rst;
    logic [31:0] data;
    logic [7:0]  dp_n;
    logic [7:0]  digit_en;
    logic        load;
    logic [7:0]  enable;
    logic [7:0]  segments;
    logic        slot_done;

    module_display_scan_8dig #(
        .N_DIGITS(8),
        .REFRESH_DIV(4),
        .BLANK_CYCLES(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data(data),
        .dp_n(dp_n),
        .digit_en(digit_en),
        .load(load),
        .enable(enable),
        .segments(segments),
        .slot_done(slot_done)
    );

    typedef struct packed {
        logic [7:0] en;
        logic [7:0] seg;
        logic       sd;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   k;

    logic [31:0] m_pend_data, m_act_data;
    logic [7:0]  m_pend_dp, m_act_dp;
    logic [7:0]  m_pend_en, m_act_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] dec(input logic [3:0] v);
        logic [6:0] tab [16];
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tab[v];
    endfunction

    // Monitor: compare each registered output against the queued expectation
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            tests++;
            if (enable !== mon_e.en || segments !== mon_e.seg || slot_done !== mon_e.sd) begin
                fails++;
                $display("FAIL scan_cycle t=%0t: enable=%h segments=%h slot_done=%b, expected %h %h %b",
                         $time, enable, segments, slot_done, mon_e.en, mon_e.seg, mon_e.sd);
            end
        end
    end

    // One clock of stimulus; the cycle model (slot = k/4, phase = k%4) predicts the outputs
    task automatic step(input logic ld, input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
        exp_t e;
        int   p, idx;
        load     = ld;
        data     = d;
        dp_n     = dp;
        digit_en = en;
        p   = k % 4;
        idx = (k / 4) % 8;
        if (p >= 1 && m_act_en[idx]) begin
            e.en  = ~(8'h01 << idx);
            e.seg = {m_act_dp[idx], dec(m_act_data[idx*4 +: 4])};
        end else begin
            e.en  = 8'hFF;
            e.seg = 8'hFF;
        end
        e.sd = ((k + 1) % 4 == 3);
        q.push_back(e);
        @(posedge clk);
        if (k % 32 == 31) begin
            m_act_data = ld ? d  : m_pend_data;
            m_act_dp   = ld ? dp : m_pend_dp;
            m_act_en   = ld ? en : m_pend_en;
        end
        if (ld) begin
            m_pend_data = d;
            m_pend_dp   = dp;
            m_pend_en   = en;
        end
        k++;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run_until(input int kt);
        while (k <= kt) step(1'b0, data, dp_n, digit_en);
    endtask

    task automatic chk(input string name, input logic [7:0] ee, input logic [7:0] es);
        tests++;
        if (enable !== ee || segments !== es) begin
            fails++;
            $display("FAIL %s: enable=%h segments=%h, expected %h %h", name, enable, segments, ee, es);
        end
    endtask

    task automatic model_reset();
        k           = 0;
        m_pend_data = '0;
        m_pend_dp   = '0;
        m_pend_en   = '0;
        m_act_data  = '0;
        m_act_dp    = '0;
        m_act_en    = '0;
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        data     = '0;
        dp_n     = '0;
        digit_en = '0;
        model_reset();

        // Reset held: dark display, no slot pulses
        repeat (3) @(negedge clk);
        chk("reset_hold", 8'hFF, 8'hFF);
        tests++;
        if (slot_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_slot_done: slot_done=%b, expected 0", slot_done);
        end
        rst = 1'b0;

        // Frame 0 dark; load digits 0..7 mid-frame
        run_until(9);
        step(1'b1, 32'h76543210, 8'hFF, 8'hFF);
        run_until(31);
        chk("frame0_dark", 8'hFF, 8'hFF);

        // Frame 1: new data visible after boundary
        run_until(32);
        chk("dig0_blank", 8'hFF, 8'hFF);
        run_until(33);
        chk("dig0_lit", 8'hFE, 8'hC0);
        run_until(44);
        step(1'b1, 32'hFFFFFFFF, 8'hFF, 8'hFF);
        run_until(49);
        chk("midframe_old", 8'hEF, 8'h99);
        run_until(61);
        chk("dig7_lit", 8'h7F, 8'hF8);

        // Frame 2: all F
        run_until(65);
        chk("frame2_dig0_F", 8'hFE, 8'h8E);
        run_until(69);
        step(1'b1, 32'h76543210, 8'hFB, 8'h05);
        run_until(85);
        chk("frame2_dig5_F", 8'hDF, 8'h8E);

        // Frame 3: only digits 0 and 2 lit, digit 2 with dp
        run_until(97);
        chk("mask_dig0", 8'hFE, 8'hC0);
        run_until(101);
        chk("mask_dig1_dark", 8'hFF, 8'hFF);
        run_until(105);
        chk("mask_dig2_dp", 8'hFB, 8'h24);
        run_until(109);
        chk("mask_dig3_dark", 8'hFF, 8'hFF);

        // Load coincident with the 7->0 wrap
        run_until(126);
        step(1'b1, 32'h89ABCDEF, 8'hFF, 8'hFF);
        run_until(129);
        chk("boundary_load_dig0", 8'hFE, 8'h8E);
        run_until(133);
        chk("boundary_load_dig1", 8'hFD, 8'h86);
        run_until(149);
        chk("dig5_before_rst", 8'hDF, 8'h88);

        // Asynchronous reset in the digit 5 slot
        #2 rst = 1'b1;
        #1;
        chk("rst_async", 8'hFF, 8'hFF);
        tests++;
        if (slot_done !== 1'b0) begin
            fails++;
            $display("FAIL rst_async_slot_done: slot_done=%b, expected 0", slot_done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        data     = '0;
        dp_n     = '0;
        digit_en = '0;

        // Pending data was discarded: next frame stays dark until a fresh load
        run_until(1);
        chk("post_rst_dark", 8'hFF, 8'hFF);
        run_until(33);
        chk("post_rst_pending_lost", 8'hFF, 8'hFF);
        run_until(39);
        step(1'b1, 32'h76543210, 8'hFF, 8'hFF);
        run_until(65);
        chk("post_rst_reload", 8'hFE, 8'hC0);
        run_until(70);

        @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
